fifo_rd_arbiter: RTL and testbench

//  Shares the single read port of the pointer-tracked FIFO among N_REQ consumers, same clock as the FIFO read side.

---
 rtl/fifo_rd_arbiter_pkg.sv | 22 ++
 rtl/fifo_rd_arbiter_if.sv | 33 +++
 rtl/fifo_rd_arbiter_rr_arbiter.sv | 38 +++
 rtl/fifo_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
// Includes the FSM state encoding and the pointer width.
package fifo_arb_pkg;

  localparam int unsigned PTR_W  = 32;
  // Wide enough for RD_LATENCY-1 with RD_LATENCY up to 4.
  localparam int unsigned WAIT_W = 2;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StDeliver
  } arb_state_e;

  // Reset value of the pointer registers: the slot just before slot 0.
  function automatic logic [PTR_W-1:0] ptr_reset(int unsigned depth);
    return PTR_W'(depth - 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Consumer-side and FIFO-side signals of the read arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface fifo_rd_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 512
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rsp_valid;
  logic [N_REQ-1:0] rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [PTR_W-1:0] rsp_ptr;
  logic             retry_err;
  logic             busy;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data_out;
  logic [PTR_W-1:0] fifo_ptr;
  logic             fifo_empty;
  logic [PTR_W-1:0] fifo_mon_ptr;

  modport master (
    input  req, rsp_ready, fifo_data_out, fifo_ptr, fifo_empty,
    output rsp_valid, rsp_data, rsp_ptr, retry_err, busy, fifo_rd_en, fifo_mon_ptr
  );

  modport slave (
    output req, rsp_ready, fifo_data_out, fifo_ptr, fifo_empty,
    input  rsp_valid, rsp_data, rsp_ptr, retry_err, busy, fifo_rd_en, fifo_mon_ptr
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// rr_ptr, wrapping N_REQ-1 -> 0, and returns it as one-hot grant plus index.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IdxW-1:0]  gnt_idx
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      // Extra bit on sum keeps rr_ptr + i from overflowing before the wrap.
      sum = {1'b0, rr_ptr} + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(N_REQ)) begin
        sum = sum - (IdxW + 1)'(N_REQ);
      end
      cand = sum[IdxW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares the FIFO read port among N_REQ consumers. Duplicate words (pointer equal
// to the last delivered one) are discarded and re-read up to MAX_RETRY times.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 512,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_RETRY  = 8
) (
  input logic              clk,
  input logic              rst,
  fifo_rd_arbiter_if.master bus
);

  localparam int unsigned IdxW   = $clog2(N_REQ);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RetryW-1:0] retry_cnt_q, retry_cnt_d;
  logic [WIDTH-1:0]  cap_data_q, cap_data_d;
  logic [PTR_W-1:0]  cap_ptr_q, cap_ptr_d;
  logic [PTR_W-1:0]  last_ptr_q, last_ptr_d;
  logic [PTR_W-1:0]  mon_ptr_q, mon_ptr_d;
  logic              hold_q, hold_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic [IdxW-1:0]   gnt_next;
  logic [RetryW-1:0] retry_inc;
  logic              retry_err;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign gnt_next  = (gnt_idx_q == IdxW'(N_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
  assign retry_inc = retry_cnt_q + RetryW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    wait_cnt_d  = wait_cnt_q;
    retry_cnt_d = retry_cnt_q;
    cap_data_d  = cap_data_q;
    cap_ptr_d   = cap_ptr_q;
    last_ptr_d  = last_ptr_q;
    mon_ptr_d   = mon_ptr_q;
    hold_d      = hold_q;
    retry_err   = 1'b0;

    case (state_q)
      StIdle: begin
        if (|arb_gnt && !bus.fifo_empty) begin
          gnt_idx_d   = arb_idx;
          retry_cnt_d = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = WAIT_W'(RD_LATENCY - 1);
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          cap_data_d = bus.fifo_data_out;
          cap_ptr_d  = bus.fifo_ptr;
          state_d    = StCheck;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      StCheck: begin
        if (hold_q) begin
          // Discard already accounted for; only waiting for data to reappear.
          if (!bus.fifo_empty) begin
            hold_d  = 1'b0;
            state_d = StIssue;
          end
        end else begin
          mon_ptr_d = cap_ptr_q;
          if (cap_ptr_q != last_ptr_q) begin
            last_ptr_d  = cap_ptr_q;
            retry_cnt_d = '0;
            state_d     = StDeliver;
          end else if (retry_inc == RetryW'(MAX_RETRY)) begin
            retry_err   = 1'b1;
            retry_cnt_d = '0;
            rr_ptr_d    = gnt_next;
            state_d     = StIdle;
          end else begin
            retry_cnt_d = retry_inc;
            if (bus.fifo_empty) begin
              hold_d = 1'b1;
            end else begin
              state_d = StIssue;
            end
          end
        end
      end
      StDeliver: begin
        if (bus.rsp_ready[gnt_idx_q]) begin
          rr_ptr_d = gnt_next;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
      cap_data_q  <= '0;
      cap_ptr_q   <= '0;
      last_ptr_q  <= ptr_reset(DEPTH);
      mon_ptr_q   <= ptr_reset(DEPTH);
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      cap_data_q  <= cap_data_d;
      cap_ptr_q   <= cap_ptr_d;
      last_ptr_q  <= last_ptr_d;
      mon_ptr_q   <= mon_ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.rsp_valid    = (state_q == StDeliver) ? (N_REQ'(1) << gnt_idx_q) : '0;
  assign bus.rsp_data     = cap_data_q;
  assign bus.rsp_ptr      = cap_ptr_q;
  assign bus.retry_err    = retry_err;
  assign bus.busy         = (state_q != StIdle);
  assign bus.fifo_rd_en   = (state_q == StIssue);
  assign bus.fifo_mon_ptr = mon_ptr_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: directed scenarios push expected deliveries,
// a negedge monitor pops and compares on every accepted response.
module tb_fifo_rd_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 512;

  typedef struct {
    int unsigned idx;
    logic [31:0] ptr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  fifo_rd_arbiter #(
    .N_REQ      (N_REQ),
    .WIDTH      (WIDTH),
    .DEPTH      (64),
    .RD_LATENCY (1),
    .MAX_RETRY  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] script[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          retry_seen = 0;
  int          valid_seen = 0;
  int          rd_cnt = 0;
  logic [31:0]      m_ptr = '0;
  logic [WIDTH-1:0] m_data = '0;

  assign bus.fifo_ptr      = m_ptr;
  assign bus.fifo_data_out = m_data;

  function automatic logic [WIDTH-1:0] data_of(logic [31:0] p);
    return {16{p ^ 32'h5A5A_C3C3}};
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(int unsigned idx, logic [31:0] p);
    exp_t e;
    e.idx = idx;
    e.ptr = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(int n, int budget, string name);
    int k = 0;
    while (delivered < n && k < budget) begin
      tick();
      k++;
    end
    if (delivered < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout delivered %0d expected %0d", name, delivered, n);
    end
  endtask

  // FIFO read-side model, one cycle latency; repeats the last word when the script runs dry.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (script.size() != 0) begin
        m_ptr  <= script[0];
        m_data <= data_of(script[0]);
        script.delete(0);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.retry_err) retry_seen++;
      if (bus.rsp_valid != '0) valid_seen++;
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp got valid %b ptr %0d expected none", bus.rsp_valid,
                   bus.rsp_ptr);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(N_REQ'(1) << e.idx));
          check("rsp_ptr", WIDTH'(bus.rsp_ptr), WIDTH'(e.ptr));
          check("rsp_data", bus.rsp_data, data_of(e.ptr));
        end
        delivered++;
      end
    end
  end

  initial begin
    int lat;
    int k;
    int base;
    int rd0;
    int v0;
    logic ok;

    rst            = 1'b1;
    bus.req        = '0;
    bus.rsp_ready  = '1;
    bus.fifo_empty = 1'b0;
    repeat (2) tick();
    check("rst_rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(0));
    check("rst_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("rst_rd_en", WIDTH'(bus.fifo_rd_en), WIDTH'(0));
    check("rst_retry_err", WIDTH'(bus.retry_err), WIDTH'(0));
    check("rst_mon_ptr", WIDTH'(bus.fifo_mon_ptr), WIDTH'(63));
    check("rst_rsp_ptr", WIDTH'(bus.rsp_ptr), WIDTH'(0));
    rst = 1'b0;
    tick();

    // Stale slot 63 discarded, then slot 0 delivered to consumer 0.
    script.push_back(32'd63);
    script.push_back(32'd0);
    push_exp(0, 32'd0);
    bus.req = 4'b0001;
    wait_deliv(1, 50, "t1_deliver");
    bus.req = '0;
    check("t1_mon_ptr", WIDTH'(bus.fifo_mon_ptr), WIDTH'(0));
    check("t1_reads", WIDTH'(rd_cnt), WIDTH'(2));
    tick();

    // Fresh reset, all four requesting: strict rotation 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) script.push_back(32'(i));
    push_exp(0, 32'd1);
    push_exp(1, 32'd2);
    push_exp(2, 32'd3);
    push_exp(3, 32'd4);
    push_exp(0, 32'd5);
    base    = delivered;
    bus.req = 4'b1111;
    lat     = 0;
    while (bus.rsp_valid == '0 && lat < 20) begin
      tick();
      lat++;
    end
    check("t2_latency", WIDTH'(lat), WIDTH'(4));
    wait_deliv(base + 5, 200, "t2_rotation");
    bus.req = '0;
    check("t2_mon_ptr", WIDTH'(bus.fifo_mon_ptr), WIDTH'(5));

    // Writer stalled at slot 5: eight discards, one retry_err, grant moves on to 3.
    rd0        = rd_cnt;
    retry_seen = 0;
    base       = delivered;
    for (int i = 0; i < 8; i++) script.push_back(32'd5);
    script.push_back(32'd6);
    push_exp(3, 32'd6);
    bus.req = 4'b0100;
    k = 0;
    while (!bus.retry_err && k < 100) begin
      tick();
      k++;
    end
    check("t3_retry_err", WIDTH'(bus.retry_err), WIDTH'(1));
    bus.req = 4'b1111;
    wait_deliv(base + 1, 50, "t3_next_grant");
    bus.req = '0;
    check("t3_retry_pulses", WIDTH'(retry_seen), WIDTH'(1));
    check("t3_reads", WIDTH'(rd_cnt - rd0), WIDTH'(9));

    // Consumer stalls 20 cycles: response must hold, no further reads.
    bus.rsp_ready = '0;
    base          = delivered;
    script.push_back(32'd7);
    push_exp(0, 32'd7);
    bus.req = 4'b0001;
    k = 0;
    while (bus.rsp_valid == '0 && k < 50) begin
      tick();
      k++;
    end
    check("t4_valid", WIDTH'(bus.rsp_valid), WIDTH'(4'b0001));
    rd0 = rd_cnt;
    ok  = 1'b1;
    repeat (20) begin
      tick();
      if (bus.rsp_valid != 4'b0001 || bus.rsp_ptr != 32'd7 || bus.rsp_data != data_of(32'd7) ||
          bus.fifo_rd_en) ok = 1'b0;
    end
    check("t4_stall_stable", WIDTH'(ok), WIDTH'(1));
    check("t4_no_reads", WIDTH'(rd_cnt - rd0), WIDTH'(0));
    bus.rsp_ready = '1;
    wait_deliv(base + 1, 20, "t4_deliver");
    bus.req = '0;

    // Empty FIFO holds the arbiter idle; leaving empty issues a read next cycle.
    bus.fifo_empty = 1'b1;
    bus.req        = 4'b0010;
    base           = delivered;
    rd0            = rd_cnt;
    ok             = 1'b1;
    repeat (5) begin
      tick();
      if (bus.busy || bus.fifo_rd_en) ok = 1'b0;
    end
    check("t5_idle_when_empty", WIDTH'(ok), WIDTH'(1));
    check("t5_no_reads", WIDTH'(rd_cnt - rd0), WIDTH'(0));
    script.push_back(32'd8);
    push_exp(1, 32'd8);
    bus.fifo_empty = 1'b0;
    tick();
    check("t5_rd_en", WIDTH'(bus.fifo_rd_en), WIDTH'(1));
    wait_deliv(base + 1, 20, "t5_deliver");
    bus.req = '0;

    // Reset while waiting on read data aborts the grant.
    script.push_back(32'd9);
    bus.req = 4'b0001;
    k = 0;
    while (!bus.fifo_rd_en && k < 20) begin
      tick();
      k++;
    end
    tick();
    check("t6_busy_in_wait", WIDTH'(bus.busy), WIDTH'(1));
    rst = 1'b1;
    #1;
    check("t6_rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(0));
    check("t6_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("t6_rd_en", WIDTH'(bus.fifo_rd_en), WIDTH'(0));
    check("t6_mon_ptr", WIDTH'(bus.fifo_mon_ptr), WIDTH'(63));
    bus.req = '0;
    tick();
    rst = 1'b0;
    v0  = valid_seen;
    repeat (10) tick();
    check("t6_no_rsp_after_reset", WIDTH'(valid_seen - v0), WIDTH'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
